// File: rtl/quaddec_pkg.sv
// Shared types and helpers for the multi-channel quadrature decoder:
// Gray-code phase encoding, {A,B} to phase mapping, and quarter-step direction.
package quaddec_pkg;

  typedef enum logic [1:0] {
    QD_NONE = 2'd0,
    QD_UP   = 2'd1,
    QD_DN   = 2'd2,
    QD_ILL  = 2'd3
  } qd_dir_e;

  localparam logic [1:0] PH_00 = 2'd0;
  localparam logic [1:0] PH_10 = 2'd1;
  localparam logic [1:0] PH_11 = 2'd2;
  localparam logic [1:0] PH_01 = 2'd3;

  // ab is {A,B}
  function automatic logic [1:0] phase_of(input logic [1:0] ab);
    logic [1:0] ph;
    case (ab)
      2'b00:   ph = PH_00;
      2'b10:   ph = PH_10;
      2'b11:   ph = PH_11;
      default: ph = PH_01;
    endcase
    return ph;
  endfunction

  // +1 mod 4 is up, -1 mod 4 is down, a jump of two phases is illegal
  function automatic qd_dir_e step_dir(input logic [1:0] ph_old, input logic [1:0] ph_new);
    logic [1:0] diff;
    qd_dir_e    dir;
    diff = ph_new - ph_old;
    case (diff)
      2'd1:    dir = QD_UP;
      2'd3:    dir = QD_DN;
      2'd2:    dir = QD_ILL;
      default: dir = QD_NONE;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/quaddec_channel.sv
// One encoder channel: synchroniser, stability filter, phase tracker, detent
// accumulator and position counter. Sticky error flag built only with QUADDEC_ERR_EN.
module quaddec_channel
  import quaddec_pkg::*;
#(
  parameter int BITS             = 8,
  parameter int SYNC_STAGES      = 2,
  parameter int FILTER_CYCLES    = 0,
  parameter int STEPS_PER_DETENT = 4,
  parameter int WRAP             = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            a_i,
  input  logic            b_i,
  input  logic            load_i,
  input  logic [BITS-1:0] load_value_i,
  input  logic            err_clr_i,
  output logic [BITS-1:0] count_o,
  output logic            step_up_o,
  output logic            step_dn_o,
  output logic            err_o
);

  localparam logic signed [3:0] ACC_MAX = 4'(STEPS_PER_DETENT - 1);
  localparam logic signed [3:0] ACC_MIN = -ACC_MAX;
  localparam logic [BITS-1:0]   CNT_MAX = {BITS{1'b1}};

  logic [2*SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0]   sv_q;
  logic [1:0]               sync_ab;
  logic                     sync_vld;
  logic [1:0]               filt_q;
  logic                     fv_q;

  // sv_q tracks which synchroniser stages hold real pin samples since reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      sv_q   <= '0;
    end else begin
      sync_q <= {sync_q[2*SYNC_STAGES-3:0], a_i, b_i};
      sv_q   <= {sv_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ab  = sync_q[2*SYNC_STAGES-1 -: 2];
  assign sync_vld = sv_q[SYNC_STAGES-1];

  if (FILTER_CYCLES == 0) begin : g_nofilt
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        filt_q <= '0;
        fv_q   <= 1'b0;
      end else if (sync_vld) begin
        filt_q <= sync_ab;
        fv_q   <= 1'b1;
      end
    end
  end else begin : g_filt
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic [1:0]    cand_q;

    // a candidate is accepted once it has been seen FILTER_CYCLES times in a row and still holds
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        filt_q <= '0;
        fv_q   <= 1'b0;
        cnt_q  <= '0;
        cand_q <= '0;
      end else if (sync_vld) begin
        if (!fv_q) begin
          filt_q <= sync_ab;
          fv_q   <= 1'b1;
          cnt_q  <= '0;
        end else if (sync_ab == filt_q) begin
          cnt_q <= '0;
        end else if (sync_ab != cand_q || cnt_q == '0) begin
          cand_q <= sync_ab;
          cnt_q  <= CW'(1);
        end else if (cnt_q == CW'(FILTER_CYCLES)) begin
          filt_q <= cand_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  logic [1:0]        ref_q, ref_d;
  logic              primed_q, primed_d;
  logic signed [3:0] acc_q, acc_d;
  logic [BITS-1:0]   count_q, count_d;
  logic              up_q, up_d, dn_q, dn_d;
  logic              ill;
  logic [1:0]        ph_new;
  qd_dir_e           dir;

  always_comb begin
    ref_d    = ref_q;
    primed_d = primed_q;
    acc_d    = acc_q;
    count_d  = count_q;
    up_d     = 1'b0;
    dn_d     = 1'b0;
    ill      = 1'b0;
    ph_new   = phase_of(filt_q);
    dir      = step_dir(ref_q, ph_new);
    if (fv_q && !primed_q) begin
      primed_d = 1'b1;
      ref_d    = ph_new;
    end else if (primed_q && ph_new != ref_q) begin
      ref_d = ph_new;
      case (dir)
        QD_UP: begin
          if (acc_q == ACC_MAX) begin
            acc_d = '0;
            up_d  = 1'b1;
          end else begin
            acc_d = acc_q + 4'sd1;
          end
        end
        QD_DN: begin
          if (acc_q == ACC_MIN) begin
            acc_d = '0;
            dn_d  = 1'b1;
          end else begin
            acc_d = acc_q - 4'sd1;
          end
        end
        QD_ILL:  ill = 1'b1;
        default: ;
      endcase
    end
    if (up_d && !(WRAP == 0 && count_q == CNT_MAX)) count_d = count_q + BITS'(1);
    if (dn_d && !(WRAP == 0 && count_q == '0))      count_d = count_q - BITS'(1);
    // a load overrides any step decoded in the same cycle
    if (load_i) begin
      count_d = load_value_i;
      acc_d   = '0;
      up_d    = 1'b0;
      dn_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ref_q    <= '0;
      primed_q <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
    end else begin
      ref_q    <= ref_d;
      primed_q <= primed_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
    end
  end

  assign count_o   = count_q;
  assign step_up_o = up_q;
  assign step_dn_o = dn_q;

`ifdef QUADDEC_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (ill)       err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_err;
  assign unused_err = ill | err_clr_i;
  assign err_o      = 1'b0;
`endif

endmodule

// File: rtl/quaddec_multi.sv
// Multi-channel quadrature decoder top: one quaddec_channel per encoder, load
// decode and count packing. Optional sticky error flags via QUADDEC_ERR_EN.
module quaddec_multi
  import quaddec_pkg::*;
#(
  parameter int CHANNELS         = 2,
  parameter int BITS             = 8,
  parameter int SYNC_STAGES      = 2,
  parameter int FILTER_CYCLES    = 0,
  parameter int STEPS_PER_DETENT = 4,
  parameter int WRAP             = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      a,
  input  logic [CHANNELS-1:0]      b,
  input  logic                     load,
  input  logic [2:0]               load_channel,
  input  logic [BITS-1:0]          load_value,
  output logic [CHANNELS*BITS-1:0] count,
  output logic [CHANNELS-1:0]      step_up,
  output logic [CHANNELS-1:0]      step_dn,
  input  logic                     err_clr,
  output logic [CHANNELS-1:0]      err
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic ld_sel;
    // out-of-range load_channel matches no instance and is ignored
    assign ld_sel = load && (load_channel == 3'(i));

    quaddec_channel #(
      .BITS             (BITS),
      .SYNC_STAGES      (SYNC_STAGES),
      .FILTER_CYCLES    (FILTER_CYCLES),
      .STEPS_PER_DETENT (STEPS_PER_DETENT),
      .WRAP             (WRAP)
    ) u_ch (
      .clk_i        (clk),
      .reset_i      (reset),
      .a_i          (a[i]),
      .b_i          (b[i]),
      .load_i       (ld_sel),
      .load_value_i (load_value),
      .err_clr_i    (err_clr),
      .count_o      (count[i*BITS +: BITS]),
      .step_up_o    (step_up[i]),
      .step_dn_o    (step_dn[i]),
      .err_o        (err[i])
    );
  end

endmodule

// File: tb/tb_quaddec_multi.sv
// Directed bench for quaddec_multi: three configurations driven by the same pins
// (defaults; WRAP=0/1 step per detent; 3-cycle filter/1 step per detent).
module tb_quaddec_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  a = '0;
  logic [1:0]  b = '0;
  logic        load = 1'b0;
  logic [2:0]  load_channel = '0;
  logic [7:0]  load_value = '0;
  logic        err_clr = 1'b0;

  logic [15:0] cnt_d0, cnt_d1, cnt_d2;
  logic [1:0]  up_d0, dn_d0, up_d1, dn_d1, up_d2, dn_d2;
  logic [1:0]  er_d0, er_d1, er_d2;

`ifdef QUADDEC_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  quaddec_multi u_d0 (
    .clk(clk), .reset(reset), .a(a), .b(b), .load(load), .load_channel(load_channel),
    .load_value(load_value), .count(cnt_d0), .step_up(up_d0), .step_dn(dn_d0),
    .err_clr(err_clr), .err(er_d0));

  quaddec_multi #(.WRAP(0), .STEPS_PER_DETENT(1)) u_d1 (
    .clk(clk), .reset(reset), .a(a), .b(b), .load(load), .load_channel(load_channel),
    .load_value(load_value), .count(cnt_d1), .step_up(up_d1), .step_dn(dn_d1),
    .err_clr(err_clr), .err(er_d1));

  quaddec_multi #(.FILTER_CYCLES(3), .STEPS_PER_DETENT(1)) u_d2 (
    .clk(clk), .reset(reset), .a(a), .b(b), .load(load), .load_channel(load_channel),
    .load_value(load_value), .count(cnt_d2), .step_up(up_d2), .step_dn(dn_d2),
    .err_clr(err_clr), .err(er_d2));

  int n_checks = 0;
  int n_fail = 0;
  int up_n[3][2];
  int dn_n[3][2];
  int both_n = 0;
  int lat1, lat2;

  // pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        up_n[0][c] += int'(up_d0[c]);
        dn_n[0][c] += int'(dn_d0[c]);
        up_n[1][c] += int'(up_d1[c]);
        dn_n[1][c] += int'(dn_d1[c]);
        up_n[2][c] += int'(up_d2[c]);
        dn_n[2][c] += int'(dn_d2[c]);
        both_n += int'(up_d0[c] & dn_d0[c]) + int'(up_d1[c] & dn_d1[c]) + int'(up_d2[c] & dn_d2[c]);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulses();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 2; c++) begin
        up_n[d][c] = 0;
        dn_n[d][c] = 0;
      end
  endtask

  task automatic set_ab(input int ch, input logic [1:0] ab);
    a[ch] = ab[1];
    b[ch] = ab[0];
    tick(10);
  endtask

  initial begin
    clr_pulses();
    tick(3);
    check("rst_cnt_d0", 32'(cnt_d0), 0);
    check("rst_cnt_d2", 32'(cnt_d2), 0);
    check("rst_steps_d0", 32'({up_d0, dn_d0}), 0);
    check("rst_err_d0", 32'(er_d0), 0);
    reset = 1'b0;
    tick(10);

    // one full detent upward on channel 0, with latency measurement
    clr_pulses();
    a[0] = 1'b1;
    lat1 = 0;
    lat2 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (lat1 == 0 && cnt_d1[7:0] != 8'd0) lat1 = i;
      if (lat2 == 0 && cnt_d2[7:0] != 8'd0) lat2 = i;
    end
    check("lat_nofilt", 32'(lat1), 4);
    check("lat_filt", 32'(lat2), 7);
    set_ab(0, 2'b11);
    set_ab(0, 2'b01);
    set_ab(0, 2'b00);
    check("up_d0_c0", 32'(cnt_d0[7:0]), 1);
    check("up_d0_c1", 32'(cnt_d0[15:8]), 0);
    check("up_d0_pulse", 32'(up_n[0][0]), 1);
    check("up_d0_nodn", 32'(dn_n[0][0]), 0);
    check("up_d1_c0", 32'(cnt_d1[7:0]), 4);
    check("up_d1_pulse", 32'(up_n[1][0]), 4);
    check("up_d2_c0", 32'(cnt_d2[7:0]), 4);

    // two reverse detents: back to 0, then wrap / saturate
    set_ab(0, 2'b01); set_ab(0, 2'b11); set_ab(0, 2'b10); set_ab(0, 2'b00);
    check("dn1_d0_c0", 32'(cnt_d0[7:0]), 0);
    check("dn1_d1_c0", 32'(cnt_d1[7:0]), 0);
    clr_pulses();
    set_ab(0, 2'b01); set_ab(0, 2'b11); set_ab(0, 2'b10); set_ab(0, 2'b00);
    check("wrap_d0_c0", 32'(cnt_d0[7:0]), 255);
    check("wrap_d0_pulse", 32'(dn_n[0][0]), 1);
    check("wrap_d0_noup", 32'(up_n[0][0]), 0);
    check("sat_d1_c0", 32'(cnt_d1[7:0]), 0);
    check("sat_d1_pulse", 32'(dn_n[1][0]), 4);
    check("wrap_d2_c0", 32'(cnt_d2[7:0]), 252);

    // two quarter-steps up then two down: cancels inside one detent
    clr_pulses();
    set_ab(0, 2'b10); set_ab(0, 2'b11);
    check("mid_d1_c0_up", 32'(cnt_d1[7:0]), 2);
    set_ab(0, 2'b10); set_ab(0, 2'b00);
    check("mid_d0_c0", 32'(cnt_d0[7:0]), 255);
    check("mid_d0_pulses", 32'(up_n[0][0] + dn_n[0][0]), 0);
    check("mid_d1_c0_dn", 32'(cnt_d1[7:0]), 0);
    check("mid_d2_c0", 32'(cnt_d2[7:0]), 252);

    // 2-cycle glitch on A of channel 1
    clr_pulses();
    a[1] = 1'b1;
    tick(2);
    a[1] = 1'b0;
    tick(12);
    check("glitch_d2_c1", 32'(cnt_d2[15:8]), 0);
    check("glitch_d2_pulses", 32'(up_n[2][1] + dn_n[2][1]), 0);
    check("glitch_d1_up", 32'(up_n[1][1]), 1);
    check("glitch_d1_dn", 32'(dn_n[1][1]), 1);

    // 4-cycle stable pulse is accepted by the filter
    clr_pulses();
    a[1] = 1'b1;
    tick(4);
    a[1] = 1'b0;
    tick(12);
    check("stable_d2_up", 32'(up_n[2][1]), 1);
    check("stable_d2_dn", 32'(dn_n[2][1]), 1);
    check("stable_d2_c1", 32'(cnt_d2[15:8]), 0);

    // load on channel 1 in the same cycle as an unfiltered step decode
    clr_pulses();
    a[1] = 1'b1;
    tick(3);
    load = 1'b1;
    load_channel = 3'd1;
    load_value = 8'h80;
    tick(1);
    load = 1'b0;
    check("load_d1_c1_next", 32'(cnt_d1[15:8]), 32'h80);
    tick(12);
    check("load_d1_c1", 32'(cnt_d1[15:8]), 32'h80);
    check("load_d1_nopulse", 32'(up_n[1][1]), 0);
    check("load_d0_c1", 32'(cnt_d0[15:8]), 32'h80);
    check("load_d2_c1", 32'(cnt_d2[15:8]), 32'h81);
    check("load_d2_pulse", 32'(up_n[2][1]), 1);
    check("load_d0_c0", 32'(cnt_d0[7:0]), 255);

    // out-of-range load channel is ignored
    load = 1'b1;
    load_channel = 3'd5;
    load_value = 8'h11;
    tick(1);
    load = 1'b0;
    tick(2);
    check("ldx_d0_c0", 32'(cnt_d0[7:0]), 255);
    check("ldx_d0_c1", 32'(cnt_d0[15:8]), 32'h80);
    check("ldx_d2_c1", 32'(cnt_d2[15:8]), 32'h81);

    // illegal 00 -> 11 on channel 0
    a[0] = 1'b1;
    b[0] = 1'b1;
    tick(12);
    check("ill_d0_err", 32'(er_d0), 32'({1'b0, ERR_ON}));
    check("ill_d2_err", 32'(er_d2), 32'({1'b0, ERR_ON}));
    check("ill_d0_c0", 32'(cnt_d0[7:0]), 255);
    check("ill_d1_c0", 32'(cnt_d1[7:0]), 0);
    check("ill_d2_c0", 32'(cnt_d2[7:0]), 252);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    check("errclr_d0", 32'(er_d0), 0);

    // partial detent, then reset with pins parked at 11
    set_ab(0, 2'b01);
    check("pre_rst_d1_c0", 32'(cnt_d1[7:0]), 1);
    reset = 1'b1;
    a[0] = 1'b1;
    b[0] = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(12);
    check("post_rst_err", 32'(er_d0), 0);
    check("post_rst_d0_c0", 32'(cnt_d0[7:0]), 0);
    check("post_rst_d0_c1", 32'(cnt_d0[15:8]), 0);
    set_ab(0, 2'b01);
    check("prime11_d1_c0", 32'(cnt_d1[7:0]), 1);
    check("prime11_err", 32'(er_d1), 0);
    set_ab(0, 2'b00);
    set_ab(0, 2'b10);
    check("acc_cleared_d0", 32'(cnt_d0[7:0]), 0);
    set_ab(0, 2'b11);
    check("detent_after_rst_d0", 32'(cnt_d0[7:0]), 1);

    check("never_both", 32'(both_n), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quaddec_multi.md
# quaddec_multi

Multi-channel, parametrised quadrature encoder decoder: the successor to the single-channel fixed-width decoder used on the UP5K encoder/LED demos. Each channel synchronises and glitch-filters its raw A/B pins, tracks the Gray-code phase, divides raw quarter-steps into detent steps, and maintains a wrapping or saturating position counter with per-step pulses. It sits between the encoder pins and UI logic such as LED selection, and replaces the separate external debouncer + decoder pair.

## Interface
- CHANNELS, 2, number of independent encoders (1..8)
- BITS, 8, counter width per channel (2..32)
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- FILTER_CYCLES, 0, cycles a new synchronised A/B value must stay stable before it is accepted; 0 = bypass
- STEPS_PER_DETENT, 4, raw quarter-steps per counted step (1, 2 or 4)
- WRAP, 1, 1 = counter wraps modulo 2^BITS; 0 = saturates at 0 and 2^BITS-1
- clk  in  1  system clock (48 MHz HFOSC domain)
- reset  in  1  synchronous, active-high reset
- a  in  CHANNELS  raw encoder A pins, asynchronous
- b  in  CHANNELS  raw encoder B pins, asynchronous
- load  in  1  one-cycle strobe: write load_value into channel load_channel
- load_channel  in  3  target channel for load
- load_value  in  BITS  value written on load
- count  out  CHANNELS*BITS  position counters, channel i in bits [i*BITS +: BITS]
- step_up  out  CHANNELS  one-cycle pulse per decoded upward detent step
- step_dn  out  CHANNELS  one-cycle pulse per decoded downward detent step
- err_clr  in  1  clears all sticky error flags
- err  out  CHANNELS  sticky illegal-transition flag (see Configuration)

## Operation
- Per channel pipeline: synchroniser -> stability filter -> phase tracker -> detent accumulator -> counter.
- Phase index from filtered {A,B}: 00->0, 10->1, 11->2, 01->3. Index +1 mod 4 = up quarter-step (A leads B); -1 mod 4 = down.
- Both bits changing in one accepted update = illegal: no quarter-step, accumulator unchanged.
- Prime flag per channel, cleared by reset: first accepted sample after reset only loads the phase reference; no step, no error.
- Accumulator: signed, range -(STEPS_PER_DETENT-1)..+(STEPS_PER_DETENT-1). Up quarter-step adds 1; reaching +STEPS_PER_DETENT clears it and issues an up step. Symmetric for down. Direction reversals mid-detent cancel.
- Up step: count+1 (WRAP=1: 2^BITS-1 -> 0; WRAP=0: hold at 2^BITS-1). Down step likewise toward 0.
- step_up/step_dn pulse on every decoded step, even when saturated and count holds. Never both high on one channel.
- load: count[load_channel] <= load_value, that channel's accumulator cleared; a step decoded on that channel in the same cycle is dropped (no pulse). load_channel >= CHANNELS ignored. Other channels unaffected.
- Reset values: count 0, step_up/step_dn 0, err 0, accumulators 0, synchroniser/filter registers 0, prime flags cleared. Reset mid-rotation discards partial detents.

## Timing
- FILTER_CYCLES=0: an A/B change sampled at edge k updates count and step pulse on edge k+SYNC_STAGES+1 (STEPS_PER_DETENT=1).
- FILTER_CYCLES=N>0: add N cycles; any change within the window restarts it, so pulses shorter than N cycles are never accepted.
- Max decodable rate: one accepted quarter-step per channel per cycle.
- load takes effect on the next edge; count visible the cycle after the strobe.
- err_clr and a new error in the same cycle: error wins (flag set).

## Configuration
- QUADDEC_ERR_EN defined: illegal transitions set err[i] sticky until reset or err_clr.
- Not defined: illegal-transition detection logic omitted, err tied to 0, err_clr ignored; illegal transitions still produce no quarter-step.

## Structure
- Package quaddec_pkg: phase index encoding constants, phase-from-AB function, up/down delta function.
- Sub-module quaddec_channel: one channel's sync, filter, phase, accumulator, counter, error flag; top generates CHANNELS instances, decodes load/load_channel, packs count.

## Test plan
- Defaults, channel 0 driven 00->10->11->01->00 with 10-cycle spacing -> one step_up pulse, count[0]=1, count[1]=0.
- Reverse sequence from count=0, WRAP=1 -> count 255 with step_dn; WRAP=0 -> count stays 0, step_dn still pulses.
- Two quarter-steps up then two down (STEPS_PER_DETENT=4) -> no pulses, count unchanged; STEPS_PER_DETENT=1 same stimulus -> count 2 then 0.
- FILTER_CYCLES=3, 2-cycle glitch on A -> no change; 4-cycle stable change -> accepted at SYNC_STAGES+3+1 cycles.
- load=1, load_channel=1, load_value=0x80 concurrent with step on ch1 -> count[1]=0x80, no step pulse; load_channel=5 with CHANNELS=2 -> no change.
- QUADDEC_ERR_EN: 00->11 after prime -> err[0]=1, count unchanged; err_clr -> err 0; post-reset pins held at 11 -> err stays 0.
